// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, sequencer state and shift helpers.
// Imported by the multicycle ALU, its combinational core and the ALU controller.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND    = 4'b0000,
    OP_OR     = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_ADD    = 4'b0011,
    OP_SUB    = 4'b0100,
    OP_SRL    = 4'b0101,
    OP_SRA    = 4'b0110,
    OP_SLL    = 4'b0111,
    OP_EQ     = 4'b1000,
    OP_NE     = 4'b1001,
    OP_SLT    = 4'b1010,
    OP_GE     = 4'b1011,
    OP_RSVD   = 4'b1100,
    OP_PASS_B = 4'b1101,
    OP_SLTU   = 4'b1110,
    OP_GEU    = 4'b1111
  } AluOp;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } AluState;

  localparam int SHAMT_W = 5;

  function automatic logic isShiftOp(AluOp op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle combinational ALU core; shifts here are full barrel shifts and
// are only used by the sequencer when the shift amount is zero.
module alu_comb
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  AluOp              Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic [DATA_W-1:0] result
);

  logic [SHAMT_W-1:0] shamt;
  logic               flag;

  assign shamt = SrcB[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    flag   = 1'b0;
    case (Operation)
      OP_AND:    result = SrcA & SrcB;
      OP_OR:     result = SrcA | SrcB;
      OP_XOR:    result = SrcA ^ SrcB;
      OP_ADD:    result = SrcA + SrcB;
      OP_SUB:    result = SrcA - SrcB;
      OP_SRL:    result = SrcA >> shamt;
      OP_SRA:    result = $unsigned($signed(SrcA) >>> shamt);
      OP_SLL:    result = SrcA << shamt;
      OP_PASS_B: result = SrcB;
      OP_EQ:     flag = (SrcA == SrcB);
      OP_NE:     flag = (SrcA != SrcB);
      OP_SLT:    flag = ($signed(SrcA) < $signed(SrcB));
      OP_GE:     flag = ($signed(SrcA) >= $signed(SrcB));
      OP_SLTU:   flag = (SrcA < SrcB);
      OP_GEU:    flag = (SrcA >= SrcB);
      default:   result = '0;
    endcase
    // Compare results are a zero-extended single bit
    if (flag) begin
      result = {{(DATA_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: non-shift ops complete in one cycle via alu_comb, shifts
// step one bit per cycle in a small sequencer with a valid/ready handshake.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUResult,
  output logic              Zero
);

  AluState            state, nextState;
  AluOp               opIn, opReg;
  logic [DATA_W-1:0]  resultReg, combResult;
  logic [SHAMT_W-1:0] shiftCount;
  logic               signBit;
  logic               accept, shiftIn;

  assign opIn    = AluOp'(Operation);
  assign shiftIn = isShiftOp(opIn) && (SrcB[SHAMT_W-1:0] != '0);

  // A flush cancels the handshake itself, so the producer never sees an accept
  assign in_ready = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  alu_comb #(.DATA_W(DATA_W)) u_comb (
    .Operation(opIn),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .result   (combResult)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    if (flush) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) nextState = shiftIn ? SHIFT : DONE;
        SHIFT:   if (shiftCount == SHAMT_W'(1)) nextState = DONE;
        DONE: begin
          if (accept) begin
            nextState = shiftIn ? SHIFT : DONE;
          end else if (out_ready) begin
            nextState = IDLE;
          end
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // Shifts load the raw operand and walk it one bit per SHIFT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resultReg  <= '0;
      shiftCount <= '0;
      opReg      <= OP_AND;
      signBit    <= 1'b0;
    end else if (flush) begin
      shiftCount <= '0;
    end else if (accept) begin
      opReg   <= opIn;
      signBit <= SrcA[DATA_W-1];
      if (shiftIn) begin
        resultReg  <= SrcA;
        shiftCount <= SrcB[SHAMT_W-1:0];
      end else begin
        resultReg  <= combResult;
        shiftCount <= '0;
      end
    end else if (state == SHIFT) begin
      shiftCount <= shiftCount - SHAMT_W'(1);
      case (opReg)
        OP_SRL:  resultReg <= {1'b0, resultReg[DATA_W-1:1]};
        OP_SRA:  resultReg <= {signBit, resultReg[DATA_W-1:1]};
        default: resultReg <= {resultReg[DATA_W-2:0], 1'b0};
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign ALUResult = resultReg;
  assign Zero      = (resultReg == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_alu_multicycle;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  int errors = 0;
  int checks = 0;

  alu_multicycle #(.DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Operation(Operation),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUResult(ALUResult),
    .Zero     (Zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] refResult(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int n;
    logic [31:0] fill;
    n = int'(b[4:0]);
    fill = (a[31] && n != 0) ? ~(32'hFFFF_FFFF >> n) : 32'h0;
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a ^ b;
      4'h3: return a + b;
      4'h4: return a - b;
      4'h5: return a >> n;
      4'h6: return (a >> n) | fill;
      4'h7: return a << n;
      4'h8: return (a == b) ? 32'd1 : 32'd0;
      4'h9: return (a != b) ? 32'd1 : 32'd0;
      4'hA: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'hB: return (int'(a) >= int'(b)) ? 32'd1 : 32'd0;
      4'hD: return b;
      4'hE: return (a < b) ? 32'd1 : 32'd0;
      4'hF: return (a >= b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int refLatency(input logic [3:0] op, input logic [31:0] b);
    if ((op == 4'h5 || op == 4'h6 || op == 4'h7) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One full transaction from IDLE with out_ready held high
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expResult;
    int expLat;
    int lat;
    logic sawReady;
    expResult = refResult(op, a, b);
    expLat    = refLatency(op, b);
    sawReady  = 1'b0;
    lat       = 0;
    @(negedge clk);
    checkOutput("ready_before_accept", {31'd0, in_ready}, 32'd1);
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) break;
      if (in_ready) sawReady = 1'b1;
      if (lat > 40) break;
    end
    checkOutput($sformatf("latency op=%0h", op), lat, expLat);
    checkOutput($sformatf("result op=%0h a=%08h b=%08h", op, a, b), ALUResult, expResult);
    checkOutput($sformatf("zero op=%0h", op), {31'd0, Zero}, {31'd0, expResult == 32'd0});
    if (expLat > 1) checkOutput("in_ready_low_in_shift", {31'd0, sawReady}, 32'd0);
  endtask

  initial begin
    logic sawValid;
    logic [31:0] ra, rb;
    logic [3:0]  rop;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    Operation = 4'h0;
    SrcA      = 32'h0;
    SrcB      = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_result", ALUResult, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);

    applyStimulus(4'h3, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(4'h6, 32'h8000_0000, 32'd4);
    applyStimulus(4'hA, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(4'hE, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(4'hF, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(4'hC, 32'h1234_5678, 32'h9ABC_DEF0);
    applyStimulus(4'h7, 32'h0000_1234, 32'h0000_0020);
    applyStimulus(4'h5, 32'hF000_000F, 32'd1);
    applyStimulus(4'h7, 32'h0000_0001, 32'd31);
    applyStimulus(4'h8, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    applyStimulus(4'h9, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    applyStimulus(4'hB, 32'h8000_0000, 32'h7FFF_FFFF);
    applyStimulus(4'hD, 32'h1111_1111, 32'hCAFE_F00D);

    // Hold the result with out_ready low, then a back-to-back accept
    @(negedge clk);
    out_ready = 1'b0;
    Operation = 4'h4;
    SrcA      = 32'd5;
    SrcB      = 32'd7;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("hold_result", ALUResult, 32'hFFFF_FFFE);
    repeat (3) begin
      @(negedge clk);
      checkOutput("hold_valid_stable", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_result_stable", ALUResult, 32'hFFFF_FFFE);
      checkOutput("hold_zero_stable", {31'd0, Zero}, 32'd0);
      checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    Operation = 4'h1;
    SrcA      = 32'h0000_00F0;
    SrcB      = 32'h0000_000F;
    in_valid  = 1'b1;
    #1;
    checkOutput("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("b2b_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("b2b_result", ALUResult, 32'h0000_00FF);

    // Flush during a long SLL
    @(negedge clk);
    Operation = 4'h7;
    SrcA      = 32'h0000_0001;
    SrcB      = 32'd31;
    in_valid  = 1'b1;
    @(posedge clk);
    sawValid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) sawValid = 1'b1;
    end
    @(negedge clk);
    if (out_valid) sawValid = 1'b1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    Operation = 4'h3;
    SrcA      = 32'd1;
    SrcB      = 32'd2;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_idle_ready", {31'd0, in_ready}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("flush_no_result", {31'd0, sawValid}, 32'd0);

    // Flush in IDLE must override a same-cycle accept
    @(negedge clk);
    flush     = 1'b1;
    in_valid  = 1'b1;
    Operation = 4'h3;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("flush_overrides_accept", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of an SRL
    @(negedge clk);
    Operation = 4'h5;
    SrcA      = 32'hFFFF_0000;
    SrcB      = 32'd20;
    in_valid  = 1'b1;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    checkOutput("mid_shift_not_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_mid_result", ALUResult, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    sawValid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("reset_no_result", {31'd0, sawValid}, 32'd0);
    checkOutput("reset_ready_after", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 8));
      applyStimulus(rop, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
